// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : General-purpose register file for the Octa16 datapath.
//               2**ADDR_W registers of DATA_W bits each. There are two
//               asynchronous read ports and one synchronous write port.
//               Register 0 is an ordinary writable register.
//
// Ports       : clk    in   1       clock; all state updates on rising edge
//               rst    in   1       synchronous active-high reset, clears all
//               wr_en  in   1       write enable
//               rd     in   ADDR_W  write address
//               din    in   DATA_W  write data
//               rs1    in   ADDR_W  read address, port 1
//               rs2    in   ADDR_W  read address, port 2
//               r1     out  DATA_W  read data, port 1
//               r2     out  DATA_W  read data, port 2
//
// Options     : REGFILE_BYPASS_EN - when defined, each read port forwards din
//               combinationally when it addresses the register being written
//               (wr_en=1, rst=0). When undefined, reads always return the
//               stored contents.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2
);

    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [C_DEPTH];

    // Reset takes priority, so a write on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[rd] <= din;
        end
    end

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_rd1 = r_regs[rs1];
    assign w_rd2 = r_regs[rs2];

`ifdef REGFILE_BYPASS_EN
    // Write-through: a read of the register being written sees din in the
    // same cycle. Gated by rst because a reset edge drops the write.
    logic w_wr_live;
    assign w_wr_live = wr_en & ~rst;

    generate
        if (1) begin : g_bypass
            assign r1 = (w_wr_live && (rs1 == rd)) ? din : w_rd1;
            assign r2 = (w_wr_live && (rs2 == rd)) ? din : w_rd2;
        end
    endgenerate
`else
    // No forwarding: a same-cycle read shows the old value until the edge.
    generate
        if (1) begin : g_no_bypass
            assign r1 = w_rd1;
            assign r2 = w_rd2;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. It covers directed corner
//               cases, a vector table of read pairs, and randomized traffic
//               checked against an array model of the register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic       clk_tb;
    logic       rst;
    logic       wr_en;
    logic [2:0] rd;
    logic [7:0] din;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] r1;
    logic [7:0] r2;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [8];

    typedef struct {
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs [5];

    reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk_tb),
        .rst   (rst),
        .wr_en (wr_en),
        .rd    (rd),
        .din   (din),
        .rs1   (rs1),
        .rs2   (rs2),
        .r1    (r1),
        .r2    (r2)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expect_rd(input logic [2:0] rs, input logic we,
                                             input logic rr, input logic [2:0] wa,
                                             input logic [7:0] wd);
        logic [7:0] v;
        v = model[rs];
`ifdef REGFILE_BYPASS_EN
        if (we && !rr && rs == wa) v = wd;
`endif
        return v;
    endfunction

    initial begin
        logic [7:0] old2;
        rst = 1'b1; wr_en = 1'b0; rd = '0; din = '0; rs1 = '0; rs2 = '0;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i); rs2 = 3'(7 - i); #1;
            check("reset_state_r1", r1, 8'h00);
            check("reset_state_r2", r2, 8'h00);
        end

        // Reset clear
        wr_en = 1'b1; rd = 3'd3; din = 8'hAA;
        tick();
        wr_en = 1'b0; rs1 = 3'd3; #1;
        check("write_aa_reg3", r1, 8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("reset_clear_reg3", r1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i); rs2 = 3'(i); #1;
            check("reset_clear_all_r1", r1, 8'h00);
            check("reset_clear_all_r2", r2, 8'h00);
        end

        // Fill / readback
        for (int n = 0; n < 8; n++) begin
            wr_en = 1'b1; rd = 3'(n); din = 8'(n);
            tick();
        end
        wr_en = 1'b0;
        vecs[0] = '{3'd1, 3'd2, 8'h01, 8'h02};
        vecs[1] = '{3'd3, 3'd4, 8'h03, 8'h04};
        vecs[2] = '{3'd5, 3'd6, 8'h05, 8'h06};
        vecs[3] = '{3'd7, 3'd0, 8'h07, 8'h00};
        vecs[4] = '{3'd7, 3'd7, 8'h07, 8'h07};
        for (int v = 0; v < 5; v++) begin
            rs1 = vecs[v].a1; rs2 = vecs[v].a2; #1;
            check("table_r1", r1, vecs[v].e1);
            check("table_r2", r2, vecs[v].e2);
        end

        // Write disable
        wr_en = 1'b0; rd = 3'd5; din = 8'hFF;
        tick();
        rs1 = 3'd5; #1;
        check("write_disable_reg5", r1, 8'h05);

        // Same-cycle read/write
        rs1 = 3'd2; rd = 3'd2; din = 8'h5A; wr_en = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
        old2 = 8'h5A;
`else
        old2 = 8'h02;
`endif
        check("same_cycle_before_edge", r1, old2);
        tick();
        wr_en = 1'b0; #1;
        check("same_cycle_after_edge", r1, 8'h5A);

        // Reset vs write
        rst = 1'b1; wr_en = 1'b1; rd = 3'd4; din = 8'h77;
        rs1 = 3'd4; #1;
        check("reset_priority_before_edge", r1, 8'h04);
        tick();
        rst = 1'b0; wr_en = 1'b0; #1;
        check("reset_priority_reg4", r1, 8'h00);

        // Randomized traffic against the array model (all zero after reset)
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        for (int it = 0; it < 400; it++) begin
            rst   = ($urandom_range(0, 19) == 0);
            wr_en = $urandom_range(0, 1) == 1;
            rd    = 3'($urandom_range(0, 7));
            din   = 8'($urandom);
            rs1   = ($urandom_range(0, 3) == 0) ? rd : 3'($urandom_range(0, 7));
            rs2   = ($urandom_range(0, 3) == 0) ? rd : 3'($urandom_range(0, 7));
            #1;
            check("rand_r1", r1, expect_rd(rs1, wr_en, rst, rd, din));
            check("rand_r2", r2, expect_rd(rs2, wr_en, rst, rd, din));
            tick();
            if (rst) begin
                for (int i = 0; i < 8; i++) model[i] = 8'h00;
            end else if (wr_en) begin
                model[rd] = din;
            end
        end
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i); rs2 = 3'(i); #1;
            check("final_r1", r1, model[i]);
            check("final_r2", r2, model[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
